// File: rtl/glip_downscale_if.sv
// Valid/ready stream bundle used on both sides of the GLIP width downscaler.
// WIDTH is the data width of this particular link.
interface glip_downscale_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/glip_downscale.sv
// GLIP width downscaler: splits each OUT_SIZE*FACTOR-bit input word into
// FACTOR output words of OUT_SIZE bits, least-significant slice first.
// A single holding register plus slice index gives back-to-back words with
// no bubble when the last slice and the next input handshake coincide.
module glip_downscale #(
  parameter int unsigned OUT_SIZE = 8,
  parameter int unsigned FACTOR   = 2
) (
  input  logic               clk,
  input  logic               rst,
  glip_downscale_if.slave    in_if,
  glip_downscale_if.master   out_if
);

  localparam int unsigned IN_SIZE = OUT_SIZE * FACTOR;
  localparam int unsigned IDX_W   = (FACTOR > 2) ? $clog2(FACTOR) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FACTOR - 1);

  // EMPTY: holding register has no unsent slices; DRAIN: it does.
  typedef enum logic {
    EMPTY = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IN_SIZE-1:0] hold_q, hold_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic last_slice;
  logic in_hs;
  logic out_hs;

  // State, holding word and slice index; reset discards any partial word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      hold_q  <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      idx_q   <= idx_d;
    end
  end

  // Handshakes, ready/valid outputs and next-state logic.
  always_comb begin
    last_slice   = (idx_q == LAST_IDX);
    out_if.valid = (state_q == DRAIN);
    // Accept a new word when empty, or when the last slice leaves this cycle.
    in_if.ready  = (state_q == EMPTY) | (out_if.ready & last_slice);
    in_hs        = in_if.valid & in_if.ready;
    out_hs       = out_if.valid & out_if.ready;

    state_d = state_q;
    hold_d  = hold_q;
    idx_d   = idx_q;

    unique case (state_q)
      EMPTY: begin
        if (in_hs) begin
          hold_d  = in_if.data;
          idx_d   = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (!last_slice) begin
            idx_d = idx_q + 1'b1;
          end else if (in_hs) begin
            hold_d = in_if.data;
            idx_d  = '0;
          end else begin
            idx_d   = '0;
            state_d = EMPTY;
          end
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Output slice mux: idx 0 selects the least-significant OUT_SIZE bits.
  always_comb begin
    out_if.data = '0;
    for (int unsigned i = 0; i < FACTOR; i++) begin
      if (idx_q == IDX_W'(i)) begin
        out_if.data = hold_q[i*OUT_SIZE +: OUT_SIZE];
      end
    end
  end

endmodule

// File: tb/tb_glip_downscale.sv
// Directed bench for glip_downscale: FACTOR=2 directed cases on one instance,
// FACTOR=4 directed plus randomised scoreboard run on a second instance.
module tb_glip_downscale;

  logic clk;
  logic rst;

  int unsigned vectors;
  int unsigned miscompares;

  glip_downscale_if #(.WIDTH(16)) a_in ();
  glip_downscale_if #(.WIDTH(8))  a_out ();
  glip_downscale_if #(.WIDTH(32)) b_in ();
  glip_downscale_if #(.WIDTH(8))  b_out ();

  glip_downscale #(.OUT_SIZE(8), .FACTOR(2)) dut_a (
    .clk    (clk),
    .rst    (rst),
    .in_if  (a_in),
    .out_if (a_out)
  );

  glip_downscale #(.OUT_SIZE(8), .FACTOR(4)) dut_b (
    .clk    (clk),
    .rst    (rst),
    .in_if  (b_in),
    .out_if (b_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic valid, input logic [7:0] data, input logic rdy);
    check({tag, "_valid"}, 64'(a_out.valid), 64'(valid));
    check({tag, "_data"},  64'(a_out.data),  64'(data));
    check({tag, "_ready"}, 64'(a_in.ready),  64'(rdy));
  endtask

  logic [7:0]  sb[$];
  logic [7:0]  exp_slice;
  logic        pend;
  int unsigned sent;
  int unsigned got;

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b0;
    a_in.valid  = 1'b0;
    a_in.data   = '0;
    a_out.ready = 1'b0;
    b_in.valid  = 1'b0;
    b_in.data   = '0;
    b_out.ready = 1'b0;
    step();
    step();
    // Reset state
    check_a("reset", 1'b0, 8'h00, 1'b1);
    check("reset_b_valid", 64'(b_out.valid), 64'd0);
    check("reset_b_ready", 64'(b_in.ready), 64'd1);
    rst = 1'b1;
    step();

    // 1. Single word
    a_in.data = 16'hBEEF; a_in.valid = 1'b1; a_out.ready = 1'b1;
    #1;
    check("t1_accept_ready", 64'(a_in.ready), 64'd1);
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t1_s0", 1'b1, 8'hEF, 1'b0);
    step();
    check_a("t1_s1", 1'b1, 8'hBE, 1'b1);
    step();
    check("t1_idle_valid", 64'(a_out.valid), 64'd0);

    // 2. Streaming three words
    a_in.data = 16'h1122; a_in.valid = 1'b1;
    #1;
    check("t2_ready0", 64'(a_in.ready), 64'd1);
    step();
    a_in.data = 16'h3344;
    #1;
    check_a("t2_22", 1'b1, 8'h22, 1'b0);
    step();
    check_a("t2_11", 1'b1, 8'h11, 1'b1);
    step();
    a_in.data = 16'h5566;
    #1;
    check_a("t2_44", 1'b1, 8'h44, 1'b0);
    step();
    check_a("t2_33", 1'b1, 8'h33, 1'b1);
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t2_66", 1'b1, 8'h66, 1'b0);
    step();
    check_a("t2_55", 1'b1, 8'h55, 1'b1);
    step();
    check("t2_idle_valid", 64'(a_out.valid), 64'd0);

    // 3. Backpressure on first slice
    a_in.data = 16'hA5C3; a_in.valid = 1'b1; a_out.ready = 1'b0;
    step();
    a_in.valid = 1'b0;
    a_in.data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_a("t3_hold", 1'b1, 8'hC3, 1'b0);
      step();
    end
    a_out.ready = 1'b1;
    #1;
    check_a("t3_c3", 1'b1, 8'hC3, 1'b0);
    step();
    check_a("t3_a5", 1'b1, 8'hA5, 1'b1);
    step();
    check("t3_idle_valid", 64'(a_out.valid), 64'd0);

    // 4. Stall on last slice with a pending input
    a_in.data = 16'h1234; a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t4_34", 1'b1, 8'h34, 1'b0);
    step();
    a_out.ready = 1'b0; a_in.valid = 1'b1; a_in.data = 16'h7788;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_a("t4_stall", 1'b1, 8'h12, 1'b0);
      step();
    end
    a_out.ready = 1'b1;
    #1;
    check_a("t4_release", 1'b1, 8'h12, 1'b1);
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t4_88", 1'b1, 8'h88, 1'b0);
    step();
    check_a("t4_77", 1'b1, 8'h77, 1'b1);
    step();
    check("t4_idle_valid", 64'(a_out.valid), 64'd0);

    // 5. Asynchronous reset mid-word
    a_in.data = 16'hBEEF; a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t5_ef", 1'b1, 8'hEF, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_a("t5_in_reset", 1'b0, 8'h00, 1'b1);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_no_be", 64'(a_out.valid), 64'd0);
      step();
    end
    a_in.data = 16'h0102; a_in.valid = 1'b1;
    step();
    a_in.valid = 1'b0;
    #1;
    check_a("t5_02", 1'b1, 8'h02, 1'b0);
    step();
    check_a("t5_01", 1'b1, 8'h01, 1'b1);
    step();
    check("t5_idle_valid", 64'(a_out.valid), 64'd0);

    // 6a. FACTOR=4 directed word
    b_in.data = 32'h44332211; b_in.valid = 1'b1; b_out.ready = 1'b1;
    step();
    b_in.valid = 1'b0;
    #1;
    check("t6_11", 64'(b_out.data), 64'h11);
    check("t6_ready_s0", 64'(b_in.ready), 64'd0);
    step();
    check("t6_22", 64'(b_out.data), 64'h22);
    step();
    check("t6_33", 64'(b_out.data), 64'h33);
    step();
    check("t6_44", 64'(b_out.data), 64'h44);
    check("t6_ready_s3", 64'(b_in.ready), 64'd1);
    step();
    check("t6_idle_valid", 64'(b_out.valid), 64'd0);

    // 6b. Random valid/ready against a slice scoreboard
    pend = 1'b0;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 30000 && (sent < 1000 || sb.size() > 0); cyc++) begin
      if (!pend && sent < 1000 && $urandom_range(3) != 0) begin
        pend      = 1'b1;
        b_in.data = $urandom;
      end
      b_in.valid  = pend;
      b_out.ready = ($urandom_range(3) != 0);
      #1;
      if (b_out.valid && b_out.ready) begin
        got++;
        if (sb.size() == 0) begin
          check("rand_spurious", 64'd1, 64'd0);
        end else begin
          exp_slice = sb.pop_front();
          check("rand_slice", 64'(b_out.data), 64'(exp_slice));
        end
      end
      if (b_in.valid && b_in.ready) begin
        for (int k = 0; k < 4; k++) sb.push_back(b_in.data[k*8 +: 8]);
        pend = 1'b0;
        sent++;
      end
      step();
    end
    b_in.valid  = 1'b0;
    b_out.ready = 1'b0;
    check("rand_words_sent", 64'(sent), 64'd1000);
    check("rand_slices_got", 64'(got), 64'd4000);
    check("rand_drained", 64'(sb.size()), 64'd0);
    step();
    check("rand_idle_valid", 64'(b_out.valid), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
